// File: rtl/index_gather_pkg.sv
// Shared types and helpers for the index_gather_rx serial-to-parallel gatherer.
// INDEX_GATHER_PARITY_EN (when defined) adds a trailing even-parity bit to each frame.
package index_gather_pkg;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

   function automatic int frame_len(input int width, input logic parity_en);
      int fl;
      if (parity_en) begin
         fl = width + 1;
      end else begin
         fl = width;
      end
      return fl;
   endfunction

   function automatic logic even_parity(input logic [32:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/index_gather_rx_node.sv
// Per-index capture node: one enabled flop with asynchronous active-low clear.
module gather_node (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic d,
   output logic q
);

   // capture the steered serial bit when this node is addressed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/index_gather_rx.sv
// Bit-serial (LSB first) to WIDTH-bit word gatherer with registered valid/ready output.
// Define INDEX_GATHER_PARITY_EN to append and check one even-parity bit per frame.
module index_gather_rx
   import index_gather_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int IDX_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             bit_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             parity_err,
   output logic [IDX_W-1:0] bit_idx
);

`ifdef INDEX_GATHER_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif
   localparam int FL = frame_len(WIDTH, PAR_EN);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FL - 1);
   localparam logic [0:0]       ST_COLLECT = COLLECT;
   localparam logic [0:0]       ST_FULL    = FULL;

   logic [0:0]       state_r, state_n_s;
   logic [IDX_W-1:0] bit_idx_r, bit_idx_n_s;
   logic [WIDTH-1:0] out_data_r, out_data_n_s;
   logic             out_valid_r, out_valid_n_s;
   logic             parity_err_r, parity_err_n_s;

   logic [FL-1:0]    node_s;
   logic [FL-1:0]    node_en_s;
   logic             accept_s;
   logic             last_s;
   logic             out_fire_s;
   logic [WIDTH-1:0] new_data_s;
   logic             new_perr_s;
   logic [WIDTH-1:0] held_data_s;
   logic             held_perr_s;

   assign bit_ready  = (state_r == ST_COLLECT);
   assign accept_s   = bit_valid && bit_ready;
   assign last_s     = accept_s && (bit_idx_r == LAST_IDX);
   assign out_fire_s = out_valid_r && out_ready;

   assign out_data   = out_data_r;
   assign out_valid  = out_valid_r;
   assign parity_err = parity_err_r;
   assign bit_idx    = bit_idx_r;

   genvar i;
   generate
      for (i = 0; i < FL; i++) begin : g_node
         assign node_en_s[i] = accept_s && (bit_idx_r == IDX_W'(i));
         gather_node u_node (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (node_en_s[i]),
            .d     (bit_in),
            .q     (node_s[i])
         );
      end
   endgenerate

   // word images: "new" bypasses the final bit straight from bit_in, "held" is the parked frame
   always_comb begin
`ifdef INDEX_GATHER_PARITY_EN
      new_data_s  = node_s[WIDTH-1:0];
      new_perr_s  = even_parity(33'(node_s[WIDTH-1:0])) ^ bit_in;
      held_data_s = node_s[WIDTH-1:0];
      held_perr_s = even_parity(33'(node_s));
`else
      new_data_s  = {bit_in, node_s[WIDTH-2:0]};
      new_perr_s  = 1'b0;
      held_data_s = node_s;
      held_perr_s = 1'b0;
`endif
   end

   // next-state for FSM, index counter and output register
   always_comb begin
      state_n_s      = state_r;
      bit_idx_n_s    = bit_idx_r;
      out_data_n_s   = out_data_r;
      out_valid_n_s  = out_valid_r;
      parity_err_n_s = parity_err_r;
      case (state_r)
         ST_COLLECT: begin
            if (out_fire_s) begin
               out_valid_n_s = 1'b0;
            end else begin
               out_valid_n_s = out_valid_r;
            end
            if (last_s) begin
               bit_idx_n_s = {IDX_W{1'b0}};
               if (!out_valid_r || out_ready) begin
                  out_data_n_s   = new_data_s;
                  parity_err_n_s = new_perr_s;
                  out_valid_n_s  = 1'b1;
               end else begin
                  state_n_s = ST_FULL;
               end
            end else if (accept_s) begin
               bit_idx_n_s = bit_idx_r + IDX_W'(1);
            end else begin
               bit_idx_n_s = bit_idx_r;
            end
         end
         ST_FULL: begin
            // out_valid is necessarily 1 here, so out_ready alone completes the handshake
            if (out_ready) begin
               out_data_n_s   = held_data_s;
               parity_err_n_s = held_perr_s;
               out_valid_n_s  = 1'b1;
               state_n_s      = ST_COLLECT;
            end else begin
               state_n_s = ST_FULL;
            end
         end
         default: begin
            state_n_s = ST_COLLECT;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_COLLECT;
         bit_idx_r    <= {IDX_W{1'b0}};
         out_data_r   <= {WIDTH{1'b0}};
         out_valid_r  <= 1'b0;
         parity_err_r <= 1'b0;
      end else begin
         state_r      <= state_n_s;
         bit_idx_r    <= bit_idx_n_s;
         out_data_r   <= out_data_n_s;
         out_valid_r  <= out_valid_n_s;
         parity_err_r <= parity_err_n_s;
      end
   end

endmodule

// File: tb/tb_index_gather_rx.sv
// Self-checking bench for index_gather_rx: directed table, corner sequences and a
// randomized run against a frame-level scoreboard (works with or without INDEX_GATHER_PARITY_EN).
module tb_index_gather_rx;

   localparam int W  = 8;
   localparam int IW = $clog2(W + 1);
`ifdef INDEX_GATHER_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          bit_in;
   logic          bit_valid;
   logic          bit_ready;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic          parity_err;
   logic [IW-1:0] bit_idx;

   index_gather_rx #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .bit_ready  (bit_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .parity_err (parity_err),
      .bit_idx    (bit_idx)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int stall_cnt = 0;

   typedef struct {
      logic [W-1:0] data;
      logic         perr;
   } word_t;

   word_t        exp_q[$];
   logic [W-1:0] xfer_data[$];
   int           xfer_cyc[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_perr_of(input logic [W-1:0] word, input logic pbit);
`ifdef INDEX_GATHER_PARITY_EN
      return (^word) ^ pbit;
`else
      return 1'b0;
`endif
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Frame-level model: words are complete after FL accepted bits; the gatherer
   // can hold at most two finished words (output register plus capture nodes).
   initial begin
      logic [FL-1:0] frame_bits;
      int            acc_cnt;
      logic          hold_prev;
      logic [W-1:0]  hold_data;
      logic          hold_perr;
      word_t         w;
      frame_bits = '0;
      acc_cnt    = 0;
      hold_prev  = 1'b0;
      hold_data  = '0;
      hold_perr  = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            acc_cnt   = 0;
            hold_prev = 1'b0;
         end else begin
            check("occupancy_out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
            check("occupancy_bit_ready", {31'd0, bit_ready}, {31'd0, exp_q.size() < 2});
            check("bit_idx_count", 32'(bit_idx), 32'(acc_cnt));
            if (hold_prev) begin
               check("hold_out_data", 32'(out_data), 32'(hold_data));
               check("hold_parity_err", {31'd0, parity_err}, {31'd0, hold_perr});
            end
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
            hold_perr = parity_err;
            if (out_valid && out_ready) begin
               check("word_available", {31'd0, exp_q.size() > 0}, 32'd1);
               if (exp_q.size() > 0) begin
                  w = exp_q.pop_front();
                  check("sb_out_data", 32'(out_data), 32'(w.data));
                  check("sb_parity_err", {31'd0, parity_err}, {31'd0, w.perr});
               end
               xfer_data.push_back(out_data);
               xfer_cyc.push_back(cyc);
            end
            if (bit_valid && bit_ready) begin
               frame_bits[acc_cnt] = bit_in;
               acc_cnt++;
               if (acc_cnt == FL) begin
                  w.data = frame_bits[W-1:0];
`ifdef INDEX_GATHER_PARITY_EN
                  w.perr = ^frame_bits;
`else
                  w.perr = 1'b0;
`endif
                  exp_q.push_back(w);
                  acc_cnt = 0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // presents one bit and returns just after the edge that accepted it; bit_valid stays high
   task automatic put_bit(input logic b);
      int n;
      n = 0;
      bit_in    = b;
      bit_valid = 1'b1;
      while (!bit_ready && n < 200) begin
         tick();
         n++;
         stall_cnt++;
      end
      if (!bit_ready) begin
         check("bit_ready_timeout", {31'd0, bit_ready}, 32'd1);
      end
      tick();
   endtask

   task automatic send_frame(input logic [W-1:0] word, input logic pbit, input logic drop);
      for (int i = 0; i < W; i++) begin
         put_bit(word[i]);
      end
`ifdef INDEX_GATHER_PARITY_EN
      put_bit(pbit);
`endif
      if (drop) begin
         bit_valid = 1'b0;
      end
   endtask

   typedef struct {
      logic [W-1:0] word;
      logic         pbit;
      logic [W-1:0] exp_data;
      logic         exp_perr;
   } vec_t;

   vec_t vecs[7];
   logic done;

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
      vecs[1] = '{8'h00, 1'b0, 8'h00, 1'b0};
      vecs[2] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
      vecs[3] = '{8'h80, 1'b1, 8'h80, 1'b0};
      vecs[4] = '{8'h01, 1'b1, 8'h01, 1'b0};
      vecs[5] = '{8'h07, 1'b1, 8'h07, 1'b0};
      vecs[6] = '{8'h07, 1'b0, 8'h07, 1'b0};
      for (int i = 0; i < 7; i++) begin
         vecs[i].exp_perr = exp_perr_of(vecs[i].word, vecs[i].pbit);
      end

      rst_n     = 1'b0;
      bit_in    = 1'b0;
      bit_valid = 1'b0;
      out_ready = 1'b1;
      done      = 1'b0;
      repeat (2) tick();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_parity_err", {31'd0, parity_err}, 32'd0);
      check("rst_bit_idx", 32'(bit_idx), 32'd0);
      rst_n = 1'b1;
      tick();
      check("rel_bit_ready", {31'd0, bit_ready}, 32'd1);

      // reset in the middle of a frame discards the partial bits
      put_bit(1'b1);
      put_bit(1'b0);
      put_bit(1'b1);
      bit_valid = 1'b0;
      check("mid_bit_idx", 32'(bit_idx), 32'd3);
      rst_n = 1'b0;
      #1;
      check("async_bit_idx", 32'(bit_idx), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("post_rst_bit_idx", 32'(bit_idx), 32'd0);
      check("post_rst_bit_ready", {31'd0, bit_ready}, 32'd1);
      send_frame(8'h5A, ^8'h5A, 1'b1);
      check("post_rst_word_valid", {31'd0, out_valid}, 32'd1);
      check("post_rst_word", 32'(out_data), 32'h5A);
      tick();
      check("post_rst_word_gone", {31'd0, out_valid}, 32'd0);

      // table of single frames with out_ready held high
      for (int i = 0; i < 7; i++) begin
         send_frame(vecs[i].word, vecs[i].pbit, 1'b1);
         check("vec_out_valid", {31'd0, out_valid}, 32'd1);
         check("vec_out_data", 32'(out_data), 32'(vecs[i].exp_data));
         check("vec_parity_err", {31'd0, parity_err}, {31'd0, vecs[i].exp_perr});
         tick();
         check("vec_handshake_done", {31'd0, out_valid}, 32'd0);
      end

      // back-to-back frames, bit_valid never dropped
      xfer_data.delete();
      xfer_cyc.delete();
      stall_cnt = 0;
      send_frame(8'h3C, ^8'h3C, 1'b0);
      send_frame(8'hC3, ^8'hC3, 1'b1);
      repeat (2) tick();
      check("b2b_no_bubble", 32'(stall_cnt), 32'd0);
      check("b2b_count", 32'(xfer_data.size()), 32'd2);
      if (xfer_data.size() == 2) begin
         check("b2b_first", 32'(xfer_data[0]), 32'h3C);
         check("b2b_second", 32'(xfer_data[1]), 32'hC3);
         check("b2b_spacing", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'(FL));
      end

      // backpressure: second frame parks in the nodes
      out_ready = 1'b0;
      send_frame(8'h11, ^8'h11, 1'b1);
      send_frame(8'h22, ^8'h22, 1'b1);
      check("bp_bit_ready", {31'd0, bit_ready}, 32'd0);
      check("bp_out_data", 32'(out_data), 32'h11);
      check("bp_bit_idx", 32'(bit_idx), 32'd0);
      tick();
      check("bp_still_held", 32'(out_data), 32'h11);
      out_ready = 1'b1;
      tick();
      check("bp_release_data", 32'(out_data), 32'h22);
      check("bp_release_valid", {31'd0, out_valid}, 32'd1);
      check("bp_release_ready", {31'd0, bit_ready}, 32'd1);
      tick();
      check("bp_drained", {31'd0, out_valid}, 32'd0);

      // randomized gaps and out_ready toggling
      xfer_data.delete();
      xfer_cyc.delete();
      fork
         begin
            for (int w = 0; w < 1000; w++) begin
               logic [W-1:0] word;
               word = W'($urandom);
               for (int b = 0; b < FL; b++) begin
                  if ($urandom_range(0, 3) == 0) begin
                     bit_valid = 1'b0;
                     bit_in    = 1'($urandom);
                     repeat ($urandom_range(1, 3)) tick();
                  end
                  if (b < W) begin
                     put_bit(word[b]);
                  end else begin
                     put_bit(1'($urandom_range(0, 1)));
                  end
               end
            end
            bit_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               out_ready = 1'($urandom_range(0, 1));
               tick();
            end
            out_ready = 1'b1;
         end
      join
      repeat (6) tick();
      check("rand_sb_empty", 32'(exp_q.size()), 32'd0);
      check("rand_word_count", 32'(xfer_data.size()), 32'd1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
